// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, opcode/funct values, ALU operation codes
// and the datapath mux encodings used by the controller and its ALU decoder.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder for the multicycle controller.
// Ports: funct  - instr[5:0]
//        aluop  - 00 add, 01 sub, 10 decode funct
//        alucontrol - ALU operation
//        bad_funct  - funct not recognised (only meaningful for aluop=10)
module mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for the shared-ALU, shared-memory multicycle MIPS core.
// Inputs : clk, reset (sync, active-high), op, funct, zero, mem_ready
// Outputs: datapath enables (pcen, irwrite, memwrite, regwrite), mux selects
//          (iord, regdst, memtoreg, alusrca, alusrcb, pcsrc), alucontrol,
//          instr_done (retire pulse), illegal_instr (unsupported op/funct).
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC; waits for mem_ready
// DECODE   | branch target -> ALUOut, dispatch on op
// MEMADR   | base + signimm for lw/sw
// MEMRD    | load data read; waits for mem_ready
// MEMWB    | load data -> rt
// MEMWR    | store write; waits for mem_ready
// EXECUTE  | R-type ALU operation
// ALUWB    | ALUOut -> rd
// BRANCH   | compare A-B, take branch from ALUOut
// ADDIEX   | A + signimm
// ADDIWB   | ALUOut -> rt
// JUMP     | jump target -> PC
module multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter bit SUPPORT_BNE  = 1'b1,
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_t     state, state_next;
  logic [1:0] aluop;
  logic       bad_funct;

  mc_aludec u_aludec (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = S_FETCH;
    pcen          = 1'b0;
    irwrite       = 1'b0;
    iord          = 1'b0;
    memwrite      = 1'b0;
    regwrite      = 1'b0;
    regdst        = 1'b0;
    memtoreg      = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = SRCB_B;
    pcsrc         = PCSRC_ALU;
    aluop         = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_BNE: begin
            if (SUPPORT_BNE) state_next = S_BRANCH;
            else             illegal_instr = 1'b1;
          end
          OP_ADDI: begin
            if (SUPPORT_ADDI) state_next = S_ADDIEX;
            else              illegal_instr = 1'b1;
          end
          OP_J:         state_next = S_JUMP;
          default:      illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca       = 1'b1;
        aluop         = ALUOP_FUNCT;
        illegal_instr = bad_funct;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = (op == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table plus
// hand-written latency and parameter sequences.
module tb_multicycle_controller;
  import mips_mc_pkg::*;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal_instr;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr;
    logic       chk;
    outs_t      exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = OP_LW;
  logic [5:0] funct = FN_ADD;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;

  logic pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic instr_done, illegal_instr;

  logic p_pcen, p_irwrite, p_iord, p_memwrite, p_regwrite, p_regdst, p_memtoreg, p_alusrca;
  logic [1:0] p_alusrcb, p_pcsrc;
  logic [2:0] p_alucontrol;
  logic p_instr_done, p_illegal_instr;

  int n_assert = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  multicycle_controller #(.SUPPORT_BNE(1'b0), .SUPPORT_ADDI(1'b0)) dut_min (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(p_pcen), .irwrite(p_irwrite), .iord(p_iord), .memwrite(p_memwrite),
    .regwrite(p_regwrite), .regdst(p_regdst), .memtoreg(p_memtoreg), .alusrca(p_alusrca),
    .alusrcb(p_alusrcb), .pcsrc(p_pcsrc), .alucontrol(p_alucontrol),
    .instr_done(p_instr_done), .illegal_instr(p_illegal_instr)
  );

  function automatic outs_t o(input logic pe, irw, io, mw, rw, rd, mtr, asa,
                              input logic [1:0] asb, pcs, input logic [2:0] alu,
                              input logic done, ill);
    return '{pe, irw, io, mw, rw, rd, mtr, asa, asb, pcs, alu, done, ill};
  endfunction

  function automatic outs_t actual();
    return '{pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, alucontrol, instr_done, illegal_instr};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op_i, input logic [5:0] fn_i,
                     input logic z, input logic mr, input logic chk, input outs_t e,
                     input string name);
    vec_t v;
    v.rst = rst; v.op = op_i; v.funct = fn_i; v.zero = z; v.mr = mr;
    v.chk = chk; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  // Structural invariants checked on every non-reset cycle
  always @(negedge clk) begin
    #2;
    if (mon_en && !reset) begin
      n_assert++;
      if ((memwrite && regwrite) || (pcen && regwrite)) begin
        n_fail++;
        $display("FAIL write_exclusive: pcen=%b memwrite=%b regwrite=%b required no overlap",
                 pcen, memwrite, regwrite);
      end
    end
  end

  task automatic run_latency(input logic [5:0] op_i, input logic z, input int fw,
                             input int mw, input int exp_cycles, input string name);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      op = op_i; funct = FN_ADD; zero = z; reset = 1'b0;
      mem_ready = !((c <= fw) || (c > fw + 3 && c <= fw + 3 + mw));
      #1;
      if (instr_done) seen = 1'b1;
    end
    n_assert++;
    if (!seen || c != exp_cycles) begin
      n_fail++;
      $display("FAIL latency_%s: got %0d cycles (done seen %0b) required %0d", name, c, seen, exp_cycles);
    end
  endtask

  outs_t e_fetch, e_fetch_w, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr_w, e_mwr;
  outs_t e_awb, e_aiex, e_aiwb, e_jmp, e_x;

  logic [5:0] r_fn  [6] = '{FN_ADD, FN_SLT, FN_SUB, FN_AND, FN_OR, 6'b111111};
  logic [2:0] r_alu [6] = '{ALU_ADD, ALU_SLT, ALU_SUB, ALU_AND, ALU_OR, ALU_ADD};
  logic       r_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    e_fetch   = o(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    e_fetch_w = o(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    e_dec     = o(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
    e_dec_ill = o(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,1);
    e_madr    = o(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    e_mrd     = o(0,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
    e_mwb     = o(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,1,0);
    e_mwr_w   = o(0,0,1,1,0,0,0,0,2'b00,2'b00,3'b010,0,0);
    e_mwr     = o(0,0,1,1,0,0,0,0,2'b00,2'b00,3'b010,1,0);
    e_awb     = o(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,1,0);
    e_aiex    = o(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    e_aiwb    = o(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,1,0);
    e_jmp     = o(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,1,0);
    e_x       = '0;

    // reset for two cycles, then lw with two MEMRD wait states
    add(1, OP_LW, FN_ADD, 0, 1, 0, e_x,      "reset0");
    add(1, OP_LW, FN_ADD, 0, 1, 0, e_x,      "reset1");
    add(0, OP_LW, FN_ADD, 0, 1, 1, e_fetch,  "lw_fetch");
    add(0, OP_LW, FN_ADD, 0, 1, 1, e_dec,    "lw_decode");
    add(0, OP_LW, FN_ADD, 0, 1, 1, e_madr,   "lw_memadr");
    add(0, OP_LW, FN_ADD, 0, 0, 1, e_mrd,    "lw_memrd_w1");
    add(0, OP_LW, FN_ADD, 0, 0, 1, e_mrd,    "lw_memrd_w2");
    add(0, OP_LW, FN_ADD, 0, 1, 1, e_mrd,    "lw_memrd_rdy");
    add(0, OP_LW, FN_ADD, 0, 1, 1, e_mwb,    "lw_memwb");
    // sw, no wait
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_fetch,  "sw_fetch");
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_dec,    "sw_decode");
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_madr,   "sw_memadr");
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_mwr,    "sw_memwr");
    // R-type sequence; the first one also waits a cycle in FETCH
    add(0, OP_RTYPE, FN_ADD, 0, 0, 1, e_fetch_w, "r_fetch_wait");
    for (int i = 0; i < 6; i++) begin
      add(0, OP_RTYPE, r_fn[i], 0, 1, 1, e_fetch, $sformatf("r%0d_fetch", i));
      add(0, OP_RTYPE, r_fn[i], 0, 1, 1, e_dec,   $sformatf("r%0d_decode", i));
      add(0, OP_RTYPE, r_fn[i], 0, 0, 1,
          o(0,0,0,0,0,0,0,1,2'b00,2'b00,r_alu[i],0,r_ill[i]), $sformatf("r%0d_execute", i));
      add(0, OP_RTYPE, r_fn[i], 0, 1, 1, e_awb,   $sformatf("r%0d_aluwb", i));
    end
    // branches: beq z=1, beq z=0, bne z=0, bne z=1 (mem_ready low is ignored)
    add(0, OP_BEQ, FN_ADD, 1, 1, 1, e_fetch, "beq1_fetch");
    add(0, OP_BEQ, FN_ADD, 1, 0, 1, e_dec,   "beq1_decode");
    add(0, OP_BEQ, FN_ADD, 1, 0, 1, o(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0), "beq1_branch");
    add(0, OP_BEQ, FN_ADD, 0, 1, 1, e_fetch, "beq0_fetch");
    add(0, OP_BEQ, FN_ADD, 0, 1, 1, e_dec,   "beq0_decode");
    add(0, OP_BEQ, FN_ADD, 0, 1, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0), "beq0_branch");
    add(0, OP_BNE, FN_ADD, 0, 1, 1, e_fetch, "bne0_fetch");
    add(0, OP_BNE, FN_ADD, 0, 1, 1, e_dec,   "bne0_decode");
    add(0, OP_BNE, FN_ADD, 0, 1, 1, o(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0), "bne0_branch");
    add(0, OP_BNE, FN_ADD, 1, 1, 1, e_fetch, "bne1_fetch");
    add(0, OP_BNE, FN_ADD, 1, 1, 1, e_dec,   "bne1_decode");
    add(0, OP_BNE, FN_ADD, 1, 1, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0), "bne1_branch");
    // addi, j, illegal opcode
    add(0, OP_ADDI, FN_ADD, 0, 1, 1, e_fetch, "addi_fetch");
    add(0, OP_ADDI, FN_ADD, 0, 1, 1, e_dec,   "addi_decode");
    add(0, OP_ADDI, FN_ADD, 0, 1, 1, e_aiex,  "addi_ex");
    add(0, OP_ADDI, FN_ADD, 0, 1, 1, e_aiwb,  "addi_wb");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_fetch, "j_fetch");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_dec,   "j_decode");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_jmp,   "j_jump");
    add(0, 6'b111111, FN_ADD, 0, 1, 1, e_fetch,   "ill_fetch");
    add(0, 6'b111111, FN_ADD, 0, 1, 1, e_dec_ill, "ill_decode");
    add(0, OP_SW, FN_ADD, 0, 0, 1, e_fetch_w,     "ill_back_to_fetch");
    // sw aborted by reset while waiting in MEMWR
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_fetch,  "swr_fetch");
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_dec,    "swr_decode");
    add(0, OP_SW, FN_ADD, 0, 1, 1, e_madr,   "swr_memadr");
    add(0, OP_SW, FN_ADD, 0, 0, 1, e_mwr_w,  "swr_memwr_wait");
    add(1, OP_SW, FN_ADD, 0, 0, 0, e_x,      "swr_reset");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_fetch,   "after_reset_fetch");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_dec,     "after_reset_decode");
    add(0, OP_J, FN_ADD, 0, 1, 1, e_jmp,     "after_reset_jump");

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].mr;
      #1;
      if (i == 2) mon_en = 1'b1;
      if (vecs[i].chk) begin
        n_assert++;
        if (actual() !== vecs[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %b required %b", vecs[i].name, actual(), vecs[i].exp);
        end
      end
    end

    // cycle counts to instr_done, with FETCH / memory wait states
    run_latency(OP_LW,    1'b0, 0, 0, 5, "lw");
    run_latency(OP_LW,    1'b0, 1, 2, 8, "lw_waits");
    run_latency(OP_SW,    1'b0, 0, 3, 7, "sw_waits");
    run_latency(OP_RTYPE, 1'b0, 2, 2, 6, "rtype_ignore_ready");
    run_latency(OP_BEQ,   1'b1, 0, 2, 3, "beq");
    run_latency(OP_J,     1'b0, 1, 2, 4, "j_fetch_wait");
    run_latency(OP_ADDI,  1'b0, 0, 2, 4, "addi");

    // build without bne/addi support flags them in DECODE
    foreach (r_fn[k]) begin
      if (k < 2) begin
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; op = (k == 0) ? OP_BNE : OP_ADDI; funct = FN_ADD;
        @(negedge clk);
        #1;
        n_assert++;
        if (p_illegal_instr !== 1'b1 || illegal_instr !== 1'b0) begin
          n_fail++;
          $display("FAIL param_illegal_%0d: got min=%b full=%b required min=1 full=0",
                   k, p_illegal_instr, illegal_instr);
        end
        @(negedge clk);
        #1;
        n_assert++;
        if (p_irwrite !== 1'b1 || p_regwrite !== 1'b0) begin
          n_fail++;
          $display("FAIL param_refetch_%0d: got irwrite=%b regwrite=%b required 1 0",
                   k, p_irwrite, p_regwrite);
        end
      end
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
